memwb_stage_param: RTL and testbench

- Parametrised MEM/WB pipeline register for the MIPS datapath. It adds the following over the fixed 22-bit stage:
  - valid bit, stall and flush;
  - JAL link-register destination select;
  - a HIST_DEPTH-deep write-back history with two combinational forwarding lookup ports (rs/rt);
  - a retired-instruction counter.
- Sits between the MEM stage and the register file / HI-LO write ports.

---
 rtl/memwb_pkg.sv | 19 +
 rtl/fwd_lookup.sv | 30 +++
 rtl/memwb_stage_param.sv | 147 ++++++++++++++
 tb/tb_memwb_stage_param.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memwb_pkg.sv
// Shared definitions for the MEM/WB stage: default control-bundle bit positions
// and the layout of one write-back history entry.
package memwb_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_REG_AW    = 5;
  localparam int DEF_RF_EN_BIT = 9;
  localparam int DEF_HI_EN_BIT = 2;
  localparam int DEF_LO_EN_BIT = 1;
  localparam int DEF_LINK_BIT  = 10;
  localparam int DEF_LINK_REG  = 31;

  typedef struct packed {
    logic                  valid;
    logic [DEF_REG_AW-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } hist_entry_t;

endpackage

// File: rtl/fwd_lookup.sv
// Priority match of one register query against the write-back history.
// The lowest index holds the newest entry and wins; register 0 never matches.
module fwd_lookup #(
  parameter int DEPTH  = 2,
  parameter int REG_AW = 5,
  parameter int DATA_W = 32
) (
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0][REG_AW-1:0] rd,
  input  logic [DEPTH-1:0][DATA_W-1:0] data,
  input  logic [REG_AW-1:0]            query,
  output logic                         hit,
  output logic [DATA_W-1:0]            hit_data
);

  // Walk oldest to newest so the newest match is the last assignment.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    if (query != '0) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (valid[i] && (rd[i] == query)) begin
          hit      = 1'b1;
          hit_data = data[i];
        end
      end
    end
  end

endmodule

// File: rtl/memwb_stage_param.sv
// MEM/WB pipeline register with valid/stall/flush, JAL link destination,
// a short write-back history with rs/rt forwarding lookups and a retire counter.
module memwb_stage_param
  import memwb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 22,
  parameter int REG_AW     = 5,
  parameter int RF_EN_BIT  = DEF_RF_EN_BIT,
  parameter int HI_EN_BIT  = DEF_HI_EN_BIT,
  parameter int LO_EN_BIT  = DEF_LO_EN_BIT,
  parameter int LINK_BIT   = DEF_LINK_BIT,
  parameter int LINK_REG   = DEF_LINK_REG,
  parameter int HIST_DEPTH = 2,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              mem_valid_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic [REG_AW-1:0] mem_rd_in,
  input  logic [REG_AW-1:0] q_rs_in,
  input  logic [REG_AW-1:0] q_rt_in,
  output logic              wb_valid_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] wb_data_out,
  output logic [REG_AW-1:0] wb_rd_out,
  output logic              rf_we_out,
  output logic              hi_we_out,
  output logic              lo_we_out,
  output logic              fwd_rs_hit_out,
  output logic [DATA_W-1:0] fwd_rs_data_out,
  output logic              fwd_rt_hit_out,
  output logic [DATA_W-1:0] fwd_rt_data_out,
  output logic [CNT_W-1:0]  retire_cnt_out
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t [HIST_DEPTH-1:0] hist;

  logic [REG_AW-1:0] rd_resolved;
  logic              rf_we_next;
  logic              advance;
  logic              record;

  assign rd_resolved = ctrl_in[LINK_BIT] ? REG_AW'(LINK_REG) : mem_rd_in;
  assign rf_we_next  = mem_valid_in & ctrl_in[RF_EN_BIT];
  assign advance     = !flush_in && !stall_in;
  assign record      = rf_we_next && (rd_resolved != '0);

  // Flush clears the control side only; data and rd keep their old values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_out <= 1'b0;
      ctrl_out     <= '0;
      wb_data_out  <= '0;
      wb_rd_out    <= '0;
      rf_we_out    <= 1'b0;
      hi_we_out    <= 1'b0;
      lo_we_out    <= 1'b0;
    end else if (flush_in) begin
      wb_valid_out <= 1'b0;
      ctrl_out     <= '0;
      rf_we_out    <= 1'b0;
      hi_we_out    <= 1'b0;
      lo_we_out    <= 1'b0;
    end else if (!stall_in) begin
      wb_valid_out <= mem_valid_in;
      ctrl_out     <= ctrl_in;
      wb_data_out  <= mem_data_in;
      wb_rd_out    <= rd_resolved;
      rf_we_out    <= rf_we_next;
      hi_we_out    <= mem_valid_in & ctrl_in[HI_EN_BIT];
      lo_we_out    <= mem_valid_in & ctrl_in[LO_EN_BIT];
    end
  end

  // The outgoing WB instruction retires on any edge that is not a pure stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_cnt_out <= '0;
    end else if ((flush_in || !stall_in) && wb_valid_out) begin
      retire_cnt_out <= retire_cnt_out + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
    end else if (advance && record) begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) begin
        hist[i] <= hist[i-1];
      end
      hist[0] <= '{valid: 1'b1, rd: rd_resolved, data: mem_data_in};
    end
  end

  logic [HIST_DEPTH-1:0]             h_valid;
  logic [HIST_DEPTH-1:0][REG_AW-1:0] h_rd;
  logic [HIST_DEPTH-1:0][DATA_W-1:0] h_data;

  always_comb begin
    h_valid = '0;
    h_rd    = '0;
    h_data  = '0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      h_valid[i] = hist[i].valid;
      h_rd[i]    = hist[i].rd;
      h_data[i]  = hist[i].data;
    end
  end

  fwd_lookup #(
    .DEPTH (HIST_DEPTH),
    .REG_AW(REG_AW),
    .DATA_W(DATA_W)
  ) u_fwd_rs (
    .valid   (h_valid),
    .rd      (h_rd),
    .data    (h_data),
    .query   (q_rs_in),
    .hit     (fwd_rs_hit_out),
    .hit_data(fwd_rs_data_out)
  );

  fwd_lookup #(
    .DEPTH (HIST_DEPTH),
    .REG_AW(REG_AW),
    .DATA_W(DATA_W)
  ) u_fwd_rt (
    .valid   (h_valid),
    .rd      (h_rd),
    .data    (h_data),
    .query   (q_rt_in),
    .hit     (fwd_rt_hit_out),
    .hit_data(fwd_rt_data_out)
  );

endmodule

// File: tb/tb_memwb_stage_param.sv
// Directed self-checking bench for memwb_stage_param (HIST_DEPTH=2, CNT_W=4).
module tb_memwb_stage_param;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 22;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  localparam logic [CTRL_W-1:0] C_RF   = 22'(1) << 9;
  localparam logic [CTRL_W-1:0] C_LINK = 22'(1) << 10;
  localparam logic [CTRL_W-1:0] C_HI   = 22'(1) << 2;
  localparam logic [CTRL_W-1:0] C_LO   = 22'(1) << 1;

  logic              clk;
  logic              reset;
  logic              stall_in;
  logic              flush_in;
  logic              mem_valid_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic [DATA_W-1:0] mem_data_in;
  logic [REG_AW-1:0] mem_rd_in;
  logic [REG_AW-1:0] q_rs_in;
  logic [REG_AW-1:0] q_rt_in;
  logic              wb_valid_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic [DATA_W-1:0] wb_data_out;
  logic [REG_AW-1:0] wb_rd_out;
  logic              rf_we_out;
  logic              hi_we_out;
  logic              lo_we_out;
  logic              fwd_rs_hit_out;
  logic [DATA_W-1:0] fwd_rs_data_out;
  logic              fwd_rt_hit_out;
  logic [DATA_W-1:0] fwd_rt_data_out;
  logic [CNT_W-1:0]  retire_cnt_out;

  int n_checks = 0;
  int n_fail   = 0;

  memwb_stage_param #(
    .DATA_W    (DATA_W),
    .CTRL_W    (CTRL_W),
    .REG_AW    (REG_AW),
    .HIST_DEPTH(2),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_in       (stall_in),
    .flush_in       (flush_in),
    .mem_valid_in   (mem_valid_in),
    .ctrl_in        (ctrl_in),
    .mem_data_in    (mem_data_in),
    .mem_rd_in      (mem_rd_in),
    .q_rs_in        (q_rs_in),
    .q_rt_in        (q_rt_in),
    .wb_valid_out   (wb_valid_out),
    .ctrl_out       (ctrl_out),
    .wb_data_out    (wb_data_out),
    .wb_rd_out      (wb_rd_out),
    .rf_we_out      (rf_we_out),
    .hi_we_out      (hi_we_out),
    .lo_we_out      (lo_we_out),
    .fwd_rs_hit_out (fwd_rs_hit_out),
    .fwd_rs_data_out(fwd_rs_data_out),
    .fwd_rt_hit_out (fwd_rt_hit_out),
    .fwd_rt_data_out(fwd_rt_data_out),
    .retire_cnt_out (retire_cnt_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle_inputs();
    stall_in     = 1'b0;
    flush_in     = 1'b0;
    mem_valid_in = 1'b0;
    ctrl_in      = '0;
    mem_data_in  = '0;
    mem_rd_in    = '0;
    q_rs_in      = '0;
    q_rt_in      = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    q_rs_in = 5'd3;
    #2;
    n_checks++; if (wb_valid_out !== 1'b0) begin n_fail++; $display("[TB] FAIL por_valid: got %0h expected 0", wb_valid_out); end
    n_checks++; if (wb_data_out !== 32'h0) begin n_fail++; $display("[TB] FAIL por_data: got %0h expected 0", wb_data_out); end
    n_checks++; if (retire_cnt_out !== 4'h0) begin n_fail++; $display("[TB] FAIL por_cnt: got %0h expected 0", retire_cnt_out); end
    @(negedge clk);
    reset        = 1'b1;
    mem_valid_in = 1'b1;
    ctrl_in      = C_RF;
    mem_rd_in    = 5'd3;
    mem_data_in  = 32'h55;
    tick();
    n_checks++; if (wb_valid_out !== 1'b1) begin n_fail++; $display("[TB] FAIL load_valid: got %0h expected 1", wb_valid_out); end
    n_checks++; if (wb_data_out !== 32'h55) begin n_fail++; $display("[TB] FAIL load_data: got %0h expected 55", wb_data_out); end
    n_checks++; if (wb_rd_out !== 5'd3) begin n_fail++; $display("[TB] FAIL load_rd: got %0d expected 3", wb_rd_out); end
    n_checks++; if (rf_we_out !== 1'b1) begin n_fail++; $display("[TB] FAIL load_rfwe: got %0h expected 1", rf_we_out); end
    tick();
    n_checks++; if (retire_cnt_out !== 4'd1) begin n_fail++; $display("[TB] FAIL load_cnt: got %0d expected 1", retire_cnt_out); end
    n_checks++; if (fwd_rs_hit_out !== 1'b1 || fwd_rs_data_out !== 32'h55) begin n_fail++; $display("[TB] FAIL load_fwd: got hit=%0h data=%0h expected hit=1 data=55", fwd_rs_hit_out, fwd_rs_data_out); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (wb_valid_out !== 1'b0) begin n_fail++; $display("[TB] FAIL async_valid: got %0h expected 0", wb_valid_out); end
    n_checks++; if (wb_data_out !== 32'h0 || wb_rd_out !== 5'd0) begin n_fail++; $display("[TB] FAIL async_data: got data=%0h rd=%0d expected 0/0", wb_data_out, wb_rd_out); end
    n_checks++; if (retire_cnt_out !== 4'd0) begin n_fail++; $display("[TB] FAIL async_cnt: got %0d expected 0", retire_cnt_out); end
    n_checks++; if (fwd_rs_hit_out !== 1'b0 || fwd_rs_data_out !== 32'h0) begin n_fail++; $display("[TB] FAIL async_fwd: got hit=%0h data=%0h expected 0/0", fwd_rs_hit_out, fwd_rs_data_out); end
    reset       = 1'b1;
    mem_rd_in   = 5'd7;
    mem_data_in = 32'h77;
    tick();
    n_checks++; if (wb_valid_out !== 1'b1 || wb_rd_out !== 5'd7 || wb_data_out !== 32'h77) begin n_fail++; $display("[TB] FAIL post_reset: got v=%0h rd=%0d data=%0h expected 1/7/77", wb_valid_out, wb_rd_out, wb_data_out); end
    n_checks++; if (retire_cnt_out !== 4'd0) begin n_fail++; $display("[TB] FAIL post_reset_cnt: got %0d expected 0", retire_cnt_out); end
  endtask

  task automatic test_normal_link();
    do_reset();
    mem_valid_in = 1'b1;
    ctrl_in      = C_RF;
    mem_rd_in    = 5'd8;
    mem_data_in  = 32'hDEADBEEF;
    tick();
    n_checks++; if (rf_we_out !== 1'b1 || wb_rd_out !== 5'd8) begin n_fail++; $display("[TB] FAIL normal: got we=%0h rd=%0d expected 1/8", rf_we_out, wb_rd_out); end
    n_checks++; if (ctrl_out !== C_RF) begin n_fail++; $display("[TB] FAIL normal_ctrl: got %0h expected %0h", ctrl_out, C_RF); end
    ctrl_in     = C_RF | C_LINK;
    mem_rd_in   = 5'd4;
    mem_data_in = 32'h12345678;
    q_rs_in     = 5'd31;
    q_rt_in     = 5'd8;
    tick();
    n_checks++; if (wb_rd_out !== 5'd31) begin n_fail++; $display("[TB] FAIL link_rd: got %0d expected 31", wb_rd_out); end
    n_checks++; if (fwd_rs_hit_out !== 1'b1 || fwd_rs_data_out !== 32'h12345678) begin n_fail++; $display("[TB] FAIL link_fwd: got hit=%0h data=%0h expected 1/12345678", fwd_rs_hit_out, fwd_rs_data_out); end
    n_checks++; if (fwd_rt_hit_out !== 1'b1 || fwd_rt_data_out !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL older_fwd: got hit=%0h data=%0h expected 1/deadbeef", fwd_rt_hit_out, fwd_rt_data_out); end
    n_checks++; if (retire_cnt_out !== 4'd1) begin n_fail++; $display("[TB] FAIL link_cnt: got %0d expected 1", retire_cnt_out); end
  endtask

  task automatic test_fwd_priority();
    do_reset();
    mem_valid_in = 1'b1;
    ctrl_in      = C_RF;
    mem_rd_in    = 5'd5;
    mem_data_in  = 32'h11;
    tick();
    mem_data_in = 32'h22;
    q_rs_in     = 5'd5;
    tick();
    n_checks++; if (fwd_rs_hit_out !== 1'b1 || fwd_rs_data_out !== 32'h22) begin n_fail++; $display("[TB] FAIL prio_newest: got hit=%0h data=%0h expected 1/22", fwd_rs_hit_out, fwd_rs_data_out); end
    mem_rd_in   = 5'd0;
    mem_data_in = 32'h99;
    q_rt_in     = 5'd0;
    tick();
    n_checks++; if (fwd_rt_hit_out !== 1'b0 || fwd_rt_data_out !== 32'h0) begin n_fail++; $display("[TB] FAIL r0_miss: got hit=%0h data=%0h expected 0/0", fwd_rt_hit_out, fwd_rt_data_out); end
    n_checks++; if (fwd_rs_hit_out !== 1'b1 || fwd_rs_data_out !== 32'h22) begin n_fail++; $display("[TB] FAIL r0_not_recorded: got hit=%0h data=%0h expected 1/22", fwd_rs_hit_out, fwd_rs_data_out); end
    mem_rd_in   = 5'd6;
    mem_data_in = 32'h33;
    tick();
    n_checks++; if (fwd_rs_hit_out !== 1'b1 || fwd_rs_data_out !== 32'h22) begin n_fail++; $display("[TB] FAIL depth_keep: got hit=%0h data=%0h expected 1/22", fwd_rs_hit_out, fwd_rs_data_out); end
    mem_rd_in   = 5'd7;
    mem_data_in = 32'h44;
    q_rt_in     = 5'd6;
    tick();
    n_checks++; if (fwd_rs_hit_out !== 1'b0 || fwd_rs_data_out !== 32'h0) begin n_fail++; $display("[TB] FAIL depth_evict: got hit=%0h data=%0h expected 0/0", fwd_rs_hit_out, fwd_rs_data_out); end
    n_checks++; if (fwd_rt_hit_out !== 1'b1 || fwd_rt_data_out !== 32'h33) begin n_fail++; $display("[TB] FAIL depth_second: got hit=%0h data=%0h expected 1/33", fwd_rt_hit_out, fwd_rt_data_out); end
  endtask

  task automatic test_stall_flush();
    do_reset();
    mem_valid_in = 1'b1;
    ctrl_in      = C_RF;
    mem_rd_in    = 5'd9;
    mem_data_in  = 32'hA1;
    tick();
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_rd_in   = 5'd10;
      mem_data_in = 32'hB2 + 32'(i);
      tick();
      n_checks++; if (wb_data_out !== 32'hA1 || wb_rd_out !== 5'd9 || wb_valid_out !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_hold[%0d]: got data=%0h rd=%0d v=%0h expected a1/9/1", i, wb_data_out, wb_rd_out, wb_valid_out); end
      n_checks++; if (retire_cnt_out !== 4'd0) begin n_fail++; $display("[TB] FAIL stall_cnt[%0d]: got %0d expected 0", i, retire_cnt_out); end
    end
    mem_data_in = 32'hB2;
    flush_in    = 1'b1;
    q_rs_in     = 5'd9;
    q_rt_in     = 5'd10;
    tick();
    n_checks++; if (wb_valid_out !== 1'b0 || rf_we_out !== 1'b0 || ctrl_out !== '0) begin n_fail++; $display("[TB] FAIL flush_bubble: got v=%0h we=%0h ctrl=%0h expected 0/0/0", wb_valid_out, rf_we_out, ctrl_out); end
    n_checks++; if (wb_data_out !== 32'hA1 || wb_rd_out !== 5'd9) begin n_fail++; $display("[TB] FAIL flush_keep: got data=%0h rd=%0d expected a1/9", wb_data_out, wb_rd_out); end
    n_checks++; if (retire_cnt_out !== 4'd1) begin n_fail++; $display("[TB] FAIL flush_cnt: got %0d expected 1", retire_cnt_out); end
    n_checks++; if (fwd_rs_hit_out !== 1'b1 || fwd_rs_data_out !== 32'hA1 || fwd_rt_hit_out !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_hist: got rs=%0h/%0h rt=%0h expected 1/a1 0", fwd_rs_hit_out, fwd_rs_data_out, fwd_rt_hit_out); end
    stall_in = 1'b0;
    flush_in = 1'b0;
    tick();
    n_checks++; if (wb_data_out !== 32'hB2 || wb_rd_out !== 5'd10 || retire_cnt_out !== 4'd1) begin n_fail++; $display("[TB] FAIL resume: got data=%0h rd=%0d cnt=%0d expected b2/10/1", wb_data_out, wb_rd_out, retire_cnt_out); end
    flush_in = 1'b1;
    tick();
    tick();
    n_checks++; if (retire_cnt_out !== 4'd2) begin n_fail++; $display("[TB] FAIL flush_idle_cnt: got %0d expected 2", retire_cnt_out); end
  endtask

  task automatic test_hilo();
    do_reset();
    mem_valid_in = 1'b0;
    ctrl_in      = C_HI | C_LO;
    tick();
    n_checks++; if (hi_we_out !== 1'b0 || lo_we_out !== 1'b0) begin n_fail++; $display("[TB] FAIL hilo_gated: got hi=%0h lo=%0h expected 0/0", hi_we_out, lo_we_out); end
    n_checks++; if (ctrl_out !== (C_HI | C_LO)) begin n_fail++; $display("[TB] FAIL hilo_ctrl: got %0h expected 6", ctrl_out); end
    mem_valid_in = 1'b1;
    tick();
    n_checks++; if (hi_we_out !== 1'b1 || lo_we_out !== 1'b1 || rf_we_out !== 1'b0) begin n_fail++; $display("[TB] FAIL hilo_on: got hi=%0h lo=%0h rf=%0h expected 1/1/0", hi_we_out, lo_we_out, rf_we_out); end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    mem_valid_in = 1'b1;
    mem_rd_in    = 5'd1;
    for (int i = 0; i < 17; i++) begin
      mem_data_in = 32'(i);
      tick();
    end
    n_checks++; if (retire_cnt_out !== 4'd0) begin n_fail++; $display("[TB] FAIL wrap_16: got %0d expected 0", retire_cnt_out); end
    mem_valid_in = 1'b0;
    tick();
    n_checks++; if (retire_cnt_out !== 4'd1) begin n_fail++; $display("[TB] FAIL wrap_17: got %0d expected 1", retire_cnt_out); end
    tick();
    n_checks++; if (retire_cnt_out !== 4'd1) begin n_fail++; $display("[TB] FAIL wrap_idle: got %0d expected 1", retire_cnt_out); end
  endtask

  initial begin
    test_reset();
    test_normal_link();
    test_fwd_priority();
    test_stall_flush();
    test_hilo();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
